// File: rtl/axicb_pkg.sv
// Shared crossbar definitions: ID field placement and the counter-width helper
// used by every outstanding-transaction tracker.
package axicb_pkg;

    localparam int ID_OFFSET = 0;

    // Bits needed to hold the values 0..n inclusive
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axicb_ostd_cnt.sv
// Outstanding-transaction tracker for one direction: occupancy counter,
// response watchdog with sticky timeout flag, and underflow detection.
module axicb_ostd_cnt
    import axicb_pkg::*;
#(
    parameter int MAX_OSTD = 4,
    parameter bit TO_EN    = 1'b1,
    parameter int TO_VAL   = 10000,
    localparam int CW      = cnt_width(MAX_OSTD),
    localparam int TW      = cnt_width(TO_VAL)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          srst,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic          full_o,
    output logic [CW-1:0] cnt_o,
    output logic [TW-1:0] wdog_o,
    output logic          timeout_o,
    output logic          underflow_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic          to_q, to_d;

    assign full_o      = (cnt_q == CW'(MAX_OSTD));
    assign underflow_o = dec_i && (cnt_q == CW'(0));
    assign cnt_o       = cnt_q;
    assign wdog_o      = wdog_q;
    assign timeout_o   = to_q;

    // Occupancy next state; saturates at both ends instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            if (cnt_q != CW'(MAX_OSTD)) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else if (dec_i && !inc_i) begin
            if (cnt_q != CW'(0)) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Watchdog next state; the flag rises together with the counter reaching the limit
    always_comb begin
        wdog_d = wdog_q;
        to_d   = to_q;
        if (TO_EN) begin
            if ((cnt_q == CW'(0)) || dec_i) begin
                wdog_d = TW'(0);
            end else if (wdog_q == TW'(TO_VAL)) begin
                wdog_d = wdog_q;
            end else begin
                wdog_d = wdog_q + TW'(1);
            end
            if (wdog_d == TW'(TO_VAL)) begin
                to_d = 1'b1;
            end else begin
                to_d = to_q;
            end
        end else begin
            wdog_d = TW'(0);
            to_d   = 1'b0;
        end
    end

    // State registers with async reset and synchronous clear
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q  <= CW'(0);
            wdog_q <= TW'(0);
            to_q   <= 1'b0;
        end else if (srst) begin
            cnt_q  <= CW'(0);
            wdog_q <= TW'(0);
            to_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wdog_q <= wdog_d;
            to_q   <= to_d;
        end
    end

endmodule

// File: rtl/axicb_mst_if.sv
// Per-master crossbar front-end: ID tagging/stripping, outstanding-request
// limiting and missing-response watchdogs.
module axicb_mst_if
    import axicb_pkg::*;
#(
    parameter int                  AXI_ID_W        = 8,
    parameter logic [AXI_ID_W-1:0] MST_ID_MASK     = 8'h00,
    parameter int                  MST_OSTDREQ_NUM = 4,
    parameter bit                  TIMEOUT_ENABLE  = 1'b1,
    parameter int                  TIMEOUT_VALUE   = 10000,
    parameter int                  AWCH_W          = 8,
    parameter int                  WCH_W           = 8,
    parameter int                  BCH_W           = 8,
    parameter int                  ARCH_W          = 8,
    parameter int                  RCH_W           = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    // master side
    input  logic              i_awvalid,
    output logic              i_awready,
    input  logic [AWCH_W-1:0] i_awch,
    input  logic              i_wvalid,
    output logic              i_wready,
    input  logic              i_wlast,
    input  logic [WCH_W-1:0]  i_wch,
    output logic              i_bvalid,
    input  logic              i_bready,
    output logic [BCH_W-1:0]  i_bch,
    input  logic              i_arvalid,
    output logic              i_arready,
    input  logic [ARCH_W-1:0] i_arch,
    output logic              i_rvalid,
    input  logic              i_rready,
    output logic              i_rlast,
    output logic [RCH_W-1:0]  i_rch,
    // switch side
    output logic              o_awvalid,
    input  logic              o_awready,
    output logic [AWCH_W-1:0] o_awch,
    output logic              o_wvalid,
    input  logic              o_wready,
    output logic              o_wlast,
    output logic [WCH_W-1:0]  o_wch,
    input  logic              o_bvalid,
    output logic              o_bready,
    input  logic [BCH_W-1:0]  o_bch,
    output logic              o_arvalid,
    input  logic              o_arready,
    output logic [ARCH_W-1:0] o_arch,
    input  logic              o_rvalid,
    output logic              o_rready,
    input  logic              o_rlast,
    input  logic [RCH_W-1:0]  o_rch,
    // status
    output logic              wr_timeout,
    output logic              rd_timeout,
    output logic              proto_err
);

    localparam int CW = cnt_width(MST_OSTDREQ_NUM);
    localparam int TW = cnt_width(TIMEOUT_VALUE);

    // Masks widened to each bus so the ID field needs no slicing when the
    // payload is the ID alone
    localparam logic [AWCH_W-1:0] AW_MASK = AWCH_W'(MST_ID_MASK) << ID_OFFSET;
    localparam logic [ARCH_W-1:0] AR_MASK = ARCH_W'(MST_ID_MASK) << ID_OFFSET;
    localparam logic [BCH_W-1:0]  B_MASK  = BCH_W'(MST_ID_MASK) << ID_OFFSET;
    localparam logic [RCH_W-1:0]  R_MASK  = RCH_W'(MST_ID_MASK) << ID_OFFSET;

    logic          wr_full_s, rd_full_s;
    logic          wr_inc_s, wr_dec_s, rd_inc_s, rd_dec_s;
    logic          wr_unf_s, rd_unf_s;
    logic          proto_err_q;
    logic [CW-1:0] unused_wr_cnt_s, unused_rd_cnt_s;
    logic [TW-1:0] unused_wr_wdog_s, unused_rd_wdog_s;

    // Gating uses only the registered full flag, so no valid->ready path appears
    assign o_awvalid = i_awvalid & ~wr_full_s;
    assign i_awready = o_awready & ~wr_full_s;
    assign o_awch    = i_awch | AW_MASK;

    assign o_arvalid = i_arvalid & ~rd_full_s;
    assign i_arready = o_arready & ~rd_full_s;
    assign o_arch    = i_arch | AR_MASK;

    assign o_wvalid  = i_wvalid;
    assign i_wready  = o_wready;
    assign o_wlast   = i_wlast;
    assign o_wch     = i_wch;

    assign i_bvalid  = o_bvalid;
    assign o_bready  = i_bready;
    assign i_bch     = o_bch & ~B_MASK;

    assign i_rvalid  = o_rvalid;
    assign o_rready  = i_rready;
    assign i_rlast   = o_rlast;
    assign i_rch     = o_rch & ~R_MASK;

    assign wr_inc_s  = o_awvalid & o_awready;
    assign wr_dec_s  = o_bvalid & i_bready;
    assign rd_inc_s  = o_arvalid & o_arready;
    assign rd_dec_s  = o_rvalid & i_rready & o_rlast;

    axicb_ostd_cnt #(
        .MAX_OSTD (MST_OSTDREQ_NUM),
        .TO_EN    (TIMEOUT_ENABLE),
        .TO_VAL   (TIMEOUT_VALUE)
    ) u_wr_cnt (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .srst        (srst),
        .inc_i       (wr_inc_s),
        .dec_i       (wr_dec_s),
        .full_o      (wr_full_s),
        .cnt_o       (unused_wr_cnt_s),
        .wdog_o      (unused_wr_wdog_s),
        .timeout_o   (wr_timeout),
        .underflow_o (wr_unf_s)
    );

    axicb_ostd_cnt #(
        .MAX_OSTD (MST_OSTDREQ_NUM),
        .TO_EN    (TIMEOUT_ENABLE),
        .TO_VAL   (TIMEOUT_VALUE)
    ) u_rd_cnt (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .srst        (srst),
        .inc_i       (rd_inc_s),
        .dec_i       (rd_dec_s),
        .full_o      (rd_full_s),
        .cnt_o       (unused_rd_cnt_s),
        .wdog_o      (unused_rd_wdog_s),
        .timeout_o   (rd_timeout),
        .underflow_o (rd_unf_s)
    );

    // Sticky protocol-error flag collecting underflow from both directions
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            proto_err_q <= 1'b0;
        end else if (srst) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_q | wr_unf_s | rd_unf_s;
        end
    end

    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_axicb_mst_if.sv
// Directed bench for axicb_mst_if: tagging, outstanding limits, watchdogs,
// underflow and asynchronous reset.
module tb_axicb_mst_if;

    logic       aclk = 1'b0;
    logic       aresetn, srst;
    logic       i_awvalid, i_awready, i_wvalid, i_wready, i_wlast;
    logic       i_bvalid, i_bready, i_arvalid, i_arready;
    logic       i_rvalid, i_rready, i_rlast;
    logic [7:0] i_awch, i_wch, i_bch, i_arch, i_rch;
    logic       o_awvalid, o_awready, o_wvalid, o_wready, o_wlast;
    logic       o_bvalid, o_bready, o_arvalid, o_arready;
    logic       o_rvalid, o_rready, o_rlast;
    logic [7:0] o_awch, o_wch, o_bch, o_arch, o_rch;
    logic       wr_timeout, rd_timeout, proto_err;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    axicb_mst_if #(
        .AXI_ID_W        (8),
        .MST_ID_MASK     (8'h10),
        .MST_OSTDREQ_NUM (4),
        .TIMEOUT_ENABLE  (1'b1),
        .TIMEOUT_VALUE   (16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
        .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
        .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
        .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
        .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
        .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
        .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch),
        .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
        .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch),
        .wr_timeout(wr_timeout), .rd_timeout(rd_timeout), .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs driven here settle before the next one
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    initial begin
        aresetn = 1'b0; srst = 1'b0;
        i_awvalid = 1'b0; i_awch = 8'h00; i_wvalid = 1'b0; i_wlast = 1'b0; i_wch = 8'h00;
        i_bready = 1'b1; i_arvalid = 1'b0; i_arch = 8'h00; i_rready = 1'b1;
        o_awready = 1'b1; o_wready = 1'b1; o_bvalid = 1'b0; o_bch = 8'h00;
        o_arready = 1'b1; o_rvalid = 1'b0; o_rlast = 1'b0; o_rch = 8'h00;
        tick(2);
        // reset state
        chk("rst_wr_timeout", {31'd0, wr_timeout}, 32'd0);
        chk("rst_rd_timeout", {31'd0, rd_timeout}, 32'd0);
        chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
        chk("rst_wr_cnt", {29'd0, dut.u_wr_cnt.cnt_o}, 32'd0);
        i_awvalid = 1'b1;
        #1 chk("rst_awvalid_ungated", {31'd0, o_awvalid}, 32'd1);
        i_awvalid = 1'b0;
        aresetn = 1'b1;
        tick(1);

        // ID tagging and pass-through
        i_awch = 8'h03; o_bch = 8'h13; i_arch = 8'h05; o_rch = 8'h15;
        i_wch = 8'hA5; i_wlast = 1'b1; i_wvalid = 1'b1; o_rlast = 1'b1;
        #1;
        chk("aw_tag", {24'd0, o_awch}, 32'h13);
        chk("b_strip", {24'd0, i_bch}, 32'h03);
        chk("ar_tag", {24'd0, o_arch}, 32'h15);
        chk("r_strip", {24'd0, i_rch}, 32'h05);
        chk("w_pass", {22'd0, o_wvalid, o_wlast, o_wch}, {22'd0, 1'b1, 1'b1, 8'hA5});
        chk("rlast_pass", {31'd0, i_rlast}, 32'd1);
        i_wvalid = 1'b0; i_wlast = 1'b0; o_rlast = 1'b0;
        tick(1);

        // write limit: four accepted, fifth blocked even during the completing B
        i_awvalid = 1'b1;
        tick(4);
        chk("wr_cnt_full", {29'd0, dut.u_wr_cnt.cnt_o}, 32'd4);
        chk("aw_gated", {30'd0, o_awvalid, i_awready}, 32'd0);
        o_bvalid = 1'b1;
        #1 chk("aw_gated_during_b", {30'd0, o_awvalid, i_awready}, 32'd0);
        tick(1);
        o_bvalid = 1'b0;
        chk("wr_cnt_after_b", {29'd0, dut.u_wr_cnt.cnt_o}, 32'd3);
        chk("aw_reopen", {30'd0, o_awvalid, i_awready}, 32'd3);
        tick(1);
        i_awvalid = 1'b0;
        chk("wr_cnt_refill", {29'd0, dut.u_wr_cnt.cnt_o}, 32'd4);
        o_bvalid = 1'b1;
        tick(4);
        o_bvalid = 1'b0;
        chk("wr_cnt_drained", {29'd0, dut.u_wr_cnt.cnt_o}, 32'd0);
        chk("no_proto_err", {31'd0, proto_err}, 32'd0);

        // simultaneous AW and B, then underflow
        i_awvalid = 1'b1;
        tick(2);
        o_bvalid = 1'b1;
        tick(1);
        i_awvalid = 1'b0;
        chk("wr_cnt_simul", {29'd0, dut.u_wr_cnt.cnt_o}, 32'd2);
        tick(2);
        chk("wr_cnt_zero", {29'd0, dut.u_wr_cnt.cnt_o}, 32'd0);
        chk("proto_err_pre", {31'd0, proto_err}, 32'd0);
        tick(1);
        o_bvalid = 1'b0;
        chk("proto_err_set", {31'd0, proto_err}, 32'd1);
        chk("wr_cnt_underflow", {29'd0, dut.u_wr_cnt.cnt_o}, 32'd0);
        srst = 1'b1;
        tick(1);
        srst = 1'b0;
        chk("proto_err_srst", {31'd0, proto_err}, 32'd0);

        // read burst: only the rlast beat retires the transaction
        i_arvalid = 1'b1;
        tick(1);
        i_arvalid = 1'b0;
        chk("rd_cnt_ar", {29'd0, dut.u_rd_cnt.cnt_o}, 32'd1);
        o_rvalid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            tick(1);
            chk("rd_cnt_mid_burst", {29'd0, dut.u_rd_cnt.cnt_o}, 32'd1);
        end
        o_rlast = 1'b1;
        tick(1);
        o_rvalid = 1'b0; o_rlast = 1'b0;
        chk("rd_cnt_burst_done", {29'd0, dut.u_rd_cnt.cnt_o}, 32'd0);

        // write watchdog with B withheld
        i_awvalid = 1'b1;
        tick(1);
        i_awvalid = 1'b0;
        tick(15);
        chk("wr_timeout_early", {31'd0, wr_timeout}, 32'd0);
        tick(1);
        chk("wr_timeout_set", {31'd0, wr_timeout}, 32'd1);
        o_bvalid = 1'b1;
        tick(1);
        o_bvalid = 1'b0;
        tick(3);
        chk("wr_timeout_sticky", {31'd0, wr_timeout}, 32'd1);
        chk("wr_cnt_after_late_b", {29'd0, dut.u_wr_cnt.cnt_o}, 32'd0);
        srst = 1'b1;
        tick(1);
        srst = 1'b0;
        chk("wr_timeout_srst", {31'd0, wr_timeout}, 32'd0);

        // read watchdog, then asynchronous reset mid-cycle
        i_arvalid = 1'b1;
        tick(3);
        i_arvalid = 1'b0;
        tick(20);
        chk("rd_cnt_three", {29'd0, dut.u_rd_cnt.cnt_o}, 32'd3);
        chk("rd_timeout_set", {31'd0, rd_timeout}, 32'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("async_rd_cnt", {29'd0, dut.u_rd_cnt.cnt_o}, 32'd0);
        chk("async_flags", {29'd0, wr_timeout, rd_timeout, proto_err}, 32'd0);
        tick(1);
        aresetn = 1'b1;
        tick(1);

        // read limit
        i_arvalid = 1'b1;
        tick(4);
        chk("rd_cnt_full", {29'd0, dut.u_rd_cnt.cnt_o}, 32'd4);
        chk("ar_gated", {30'd0, o_arvalid, i_arready}, 32'd0);
        i_arvalid = 1'b0;
        tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/axicb_mst_if.md
# axicb_mst_if

Per-master front-end of the AXI crossbar, placed between one master port and the master-side input of the crossbar switch. It tags outgoing AW/AR IDs with the master's routing mask and strips that mask from returning B/R IDs. It limits outstanding write and read transactions to a configured depth. It also runs a watchdog that flags a missing B or R response. One instance per master; its `o_*` ports feed one lane of the master switch.

## Interface
Parameters:
- `AXI_ID_W`, 8: ID field width; ID occupies bits `[AXI_ID_W-1:0]` of every channel bus.
- `MST_ID_MASK`, 'h00: routing mask of this master, `AXI_ID_W` bits.
- `MST_OSTDREQ_NUM`, 4: maximum outstanding transactions per direction (≥1).
- `TIMEOUT_ENABLE`, 1: 1 enables the watchdogs; 0 ties the timeout flags to 0.
- `TIMEOUT_VALUE`, 10000: cycles without a response before the flag sets (≥1).
- `AWCH_W`, `WCH_W`, `BCH_W`, `ARCH_W`, `RCH_W`, 8 each: packed channel payload widths.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: reset, asynchronous active-low.
- `srst` in 1: synchronous clear, active-high; same effect as reset.
- `i_awvalid`/`i_awready`/`i_awch` in/out/in, 1/1/AWCH_W: master AW.
- `i_wvalid`/`i_wready`/`i_wlast`/`i_wch` in/out/in/in, 1/1/1/WCH_W: master W.
- `i_bvalid`/`i_bready`/`i_bch` out/in/out, 1/1/BCH_W: master B.
- `i_arvalid`/`i_arready`/`i_arch` in/out/in, 1/1/ARCH_W: master AR.
- `i_rvalid`/`i_rready`/`i_rlast`/`i_rch` out/in/out/out, 1/1/1/RCH_W: master R.
- `o_*`: the same signal set toward the switch, with directions mirrored.
- `wr_timeout` out 1: sticky, write watchdog expired.
- `rd_timeout` out 1: sticky, read watchdog expired.
- `proto_err` out 1: sticky, B or R completion arrived while the matching counter was 0.

## Operation
- **ID tagging:**
  - AW/AR forward: ID = `i_id | MST_ID_MASK`; the other payload bits pass unchanged.
  - B/R return: ID = `o_id & ~MST_ID_MASK`.
  - Masters must not drive mask bits.
- **W channel:** pure pass-through of all W signals.
- **Write counter `wr_cnt`** (0..MST_OSTDREQ_NUM, width `$clog2(MST_OSTDREQ_NUM+1)`):
  - +1 on each AW handshake at `o_*`; −1 on each B handshake.
  - Both in the same cycle: no change.
- **Read counter `rd_cnt`:**
  - +1 on each AR handshake; −1 on each R handshake with `rlast`=1.
  - R beats without `rlast` do not change the count.
- **Gating:**
  - When `wr_cnt == MST_OSTDREQ_NUM`: `o_awvalid`=0 and `i_awready`=0, even if a B completes that cycle.
  - Same rule for AR with `rd_cnt`.
- **Underflow:** a completion arriving with counter 0 leaves the counter at 0 and sets `proto_err`.
- **Watchdog** (per direction, counter width `$clog2(TIMEOUT_VALUE+1)`):
  - Clears when the direction's counter is 0 or on a completion handshake; otherwise increments each cycle.
  - On reaching `TIMEOUT_VALUE`, the timeout flag sets and the watchdog holds.
  - Flags clear only on reset or `srst`.
  - Traffic is never blocked by a timeout.

## Timing
- All valid, ready and payload paths are combinational; zero added latency.
- Counters and flags are registered; a handshake in cycle N is visible from cycle N+1.
- A blocked AW/AR reopens in the cycle after the completing B/R handshake.
- The `o_awvalid` gate depends only on registered state, so no valid→ready loop is added.
- Reset values (aresetn low or `srst`):
  - Counters and watchdogs = 0.
  - `wr_timeout`, `rd_timeout`, `proto_err` = 0.
  - All valid/ready outputs follow their inputs ungated.
- Reset mid-burst drops all tracking; the system must reset the fabric together with this block.

## Structure
- Shared crossbar package holds:
  - ID-field offset 0.
  - Counter-width helper `$clog2(N+1)`.
- Sub-module `axicb_ostd_cnt`, instantiated twice (write, read). Ports: inc, dec, full, counter, watchdog, timeout flag, underflow pulse.
- Top level holds ID muxing, gating and the `proto_err` OR.

## Test plan
- `MST_OSTDREQ_NUM`=4, 4 AW handshakes, no B → 5th AW: `o_awvalid`=0, `i_awready`=0. One B handshake → AW accepted the next cycle.
- `MST_ID_MASK`=0x10, `i_awch` ID=0x03 → `o_awch` ID=0x13. `o_bch` ID=0x13 → `i_bch` ID=0x03. Same check on AR/R.
- AR then 4 R beats with `rlast` on beat 4 → `rd_cnt` stays 1 through beat 3 and reaches 0 the cycle after beat 4.
- `TIMEOUT_VALUE`=16, one AW, B withheld → `wr_timeout`=1 after 16 cycles and stays 1 after B arrives; `srst` pulse → 0.
- `wr_cnt`=2, AW and B handshake in the same cycle → `wr_cnt`=2. B with `wr_cnt`=0 → `proto_err`=1, `wr_cnt`=0.
- `rd_cnt`=3 with `rd_timeout`=1, `aresetn` pulsed low mid-cycle → all counters and flags 0 immediately, before the next clock edge.
